// File: rtl/btt_pkg.sv
// rtl/btt_pkg.sv - shared types and defaults for the branch target table
package btt_pkg;

   typedef enum logic [1:0] {
      CLEAR_ALL  = 2'd0,
      IDLE       = 2'd1,
      CLEAR_BANK = 2'd2
   } btt_state_t;

   localparam int BTT_D         = 12;
   localparam int BTT_A         = 5;
   localparam int BTT_BANKS     = 2;
   localparam int BTT_NO_BRANCH = 0;

endpackage

// File: rtl/btt_storage.sv
// rtl/btt_storage.sv - flat target array with valid bits, one write, one registered read, one clear port
module btt_storage #(
   parameter int D  = 12,
   parameter int IW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [D-1:0]  wdata_i,
   input  logic          clr_en_i,
   input  logic [IW-1:0] clr_addr_i,
   input  logic          re_i,
   input  logic [IW-1:0] raddr_i,
   output logic [D-1:0]  rdata_o,
   output logic          rvalid_o
);

   localparam int DEPTH = 2 ** IW;

   logic [D-1:0]     mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [D-1:0]     rdata_q;
   logic             rvalid_q;

   // Target words are never reset; only the valid bits gate what is seen.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (clr_en_i) valid_q[clr_addr_i] <= 1'b0;
      else if (we_i) valid_q[waddr_i] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else if (re_i) begin
         rdata_q  <= mem_q[raddr_i];
         rvalid_q <= valid_q[raddr_i];
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - banked branch-target lookup with clear sequencer and write-first forwarding
module branch_target_table
   import btt_pkg::*;
#(
   parameter int D     = BTT_D,
   parameter int A     = BTT_A,
   parameter int BANKS = BTT_BANKS,
   localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [BW-1:0] bank_sel,
   input  logic          rd_en,
   input  logic [A-1:0]  rd_addr,
   output logic [D-1:0]  target,
   output logic          hit,
   input  logic          wr_en,
   input  logic [BW-1:0] wr_bank,
   input  logic [A-1:0]  wr_addr,
   input  logic [D-1:0]  wr_data,
   output logic          wr_ready,
   input  logic          inv_en,
   input  logic [BW-1:0] inv_bank,
   output logic          busy
);

   localparam int            IW        = A + BW;
   localparam logic [IW-1:0] LAST_ALL  = IW'(BANKS * (2 ** A) - 1);
   localparam logic [A-1:0]  LAST_BANK = {A{1'b1}};
   localparam logic [BW:0]   NBANKS    = (BW + 1)'(BANKS);
   localparam logic [A-1:0]  NO_BRANCH = A'(BTT_NO_BRANCH);

   btt_state_t    state_q, state_d;
   logic [IW-1:0] clr_idx_q, clr_idx_d;
   logic [BW-1:0] inv_bank_q, inv_bank_d;
   logic [IW-1:0] clr_addr;
   logic          clr_en;

   logic          rd_ok, wr_ok, fwd;
   logic          ok_q, fwd_q;
   logic [D-1:0]  fwd_data_q;
   logic [D-1:0]  rdata;
   logic          rvalid;

   assign wr_ready = (state_q == IDLE);
   assign busy     = ~wr_ready;

   assign wr_ok = wr_en && wr_ready && ({1'b0, wr_bank} < NBANKS) && (wr_addr != NO_BRANCH);
   assign rd_ok = rd_en && wr_ready && ({1'b0, bank_sel} < NBANKS) && (rd_addr != NO_BRANCH);
   assign fwd   = rd_ok && wr_ok && (wr_bank == bank_sel) && (wr_addr == rd_addr);

   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      inv_bank_d = inv_bank_q;
      clr_en     = 1'b0;
      clr_addr   = clr_idx_q;
      case (state_q)
         CLEAR_ALL: begin
            clr_en = 1'b1;
            if (clr_idx_q == LAST_ALL) begin
               state_d   = IDLE;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + IW'(1);
            end
         end
         CLEAR_BANK: begin
            clr_en   = 1'b1;
            clr_addr = {inv_bank_q, clr_idx_q[A-1:0]};
            if (clr_idx_q[A-1:0] == LAST_BANK) begin
               state_d   = IDLE;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + IW'(1);
            end
         end
         IDLE: begin
            // A write sampled alongside inv_en lands first; the clear then erases it.
            if (inv_en && ({1'b0, inv_bank} < NBANKS)) begin
               state_d    = CLEAR_BANK;
               inv_bank_d = inv_bank;
               clr_idx_d  = '0;
            end
         end
         default: state_d = CLEAR_ALL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR_ALL;
         clr_idx_q  <= '0;
         inv_bank_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         inv_bank_q <= inv_bank_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ok_q       <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else if (rd_en) begin
         ok_q       <= rd_ok;
         fwd_q      <= fwd;
         fwd_data_q <= wr_data;
      end
   end

   btt_storage #(.D(D), .IW(IW)) u_storage (
      .clk       (clk),
      .reset     (reset),
      .we_i      (wr_ok),
      .waddr_i   ({wr_bank, wr_addr}),
      .wdata_i   (wr_data),
      .clr_en_i  (clr_en),
      .clr_addr_i(clr_addr),
      .re_i      (rd_en),
      .raddr_i   ({bank_sel, rd_addr}),
      .rdata_o   (rdata),
      .rvalid_o  (rvalid)
   );

   // A miss, reserved index, bad bank or busy lookup all collapse to target=0.
   assign hit    = ok_q && (fwd_q || rvalid);
   assign target = !hit ? '0 : (fwd_q ? fwd_data_q : rdata);

endmodule

// File: doc/branch_target_table.md
# branch_target_table

Programmable, banked branch-target lookup for the fetch stage: maps a branch index from the instruction to an absolute PC target. It replaces the hard-coded per-program target list with a runtime-loaded table holding `BANKS` independent programs, each with `2**A` entries. Lookups are registered and return a hit flag. A sequencer clears all valid bits after reset and on a per-bank invalidate command. The loader/testbench fills the table through a write port before fetch starts.

## Interface
- `D`, 12: target (PC) width
- `A`, 5: index width; entries per bank = `2**A`
- `BANKS`, 2: number of program banks; bank-select width `BW = $clog2(BANKS)`, minimum 1
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `bank_sel` input BW: bank used for lookups
- `rd_en` input 1: lookup request
- `rd_addr` input A: branch index
- `target` output D: looked-up target; 0 on miss
- `hit` output 1: registered; 1 = valid entry returned
- `wr_en` input 1: write request
- `wr_bank` input BW: bank to write
- `wr_addr` input A: index to write
- `wr_data` input D: target value to store
- `wr_ready` output 1: write is accepted when `wr_en && wr_ready`
- `inv_en` input 1: invalidate request for one bank
- `inv_bank` input BW: bank to invalidate
- `busy` output 1: high while any clear is in progress

## Operation
- Storage: `BANKS*2**A` entries. Each entry holds a D-bit target and 1 valid bit.
- FSM states:
  - CLEAR_ALL: entered on reset; clears every valid bit.
  - IDLE
  - CLEAR_BANK: clears the valid bits of one latched bank.
- Clear index counter `clr_idx`:
  - Width A+BW in CLEAR_ALL, A in CLEAR_BANK.
  - Clears one entry per cycle.
  - Terminal count goes to IDLE on the following edge.
- IDLE transitions:
  - If `inv_en`, go to CLEAR_BANK, latch `inv_bank`, and set `clr_idx=0`.
  - Otherwise stay in IDLE.
- `inv_en` is ignored outside IDLE.
- `inv_bank` values of `BANKS` or above are ignored (no transition).
- Write:
  - `wr_ready = (state==IDLE)`.
  - On an accepted write, store `wr_data` and set valid.
  - Writes with `wr_addr==0` are accepted but discarded; index 0 is the reserved "no branch" slot.
  - `wr_bank` values of `BANKS` or above are discarded.
- Lookup result:
  - If `rd_en` is high in IDLE: `target` = entry, `hit`=1 when the entry is valid.
  - On miss, index 0, or an out-of-range bank: `target`=0, `hit`=0.
  - If `rd_en` is high while busy: `target`=0, `hit`=0.
  - If `rd_en` is low: `target` and `hit` hold their previous value.
- Read-during-write to the same bank and index in the same cycle is write-first: the result is `wr_data` with `hit=1`.
- Simultaneous `wr_en` and `inv_en` in IDLE:
  - The write is accepted first.
  - The clear starts next cycle, so a write into the invalidated bank is erased.
- Target data is not cleared, only valid bits. A cleared entry never reports stale data, because a miss forces `target=0`.

## Timing
- Reset values: `target=0`, `hit=0`, `busy=1`, `wr_ready=0`, state=CLEAR_ALL, `clr_idx=0`.
- Reset asserted mid-clear or mid-operation restarts CLEAR_ALL from index 0.
- CLEAR_ALL lasts `BANKS*2**A` cycles (64 at defaults) after reset deasserts. `busy` falls on the edge that enters IDLE.
- CLEAR_BANK lasts `2**A` cycles (32 at defaults). `busy` rises on the edge after `inv_en` is sampled.
- Lookup latency is 1 cycle: inputs sampled at edge N, `target`/`hit` valid after edge N and stable until the next `rd_en` edge.
- A write at edge N is visible to a lookup sampled at edge N (forwarded) and to all later lookups.
- `wr_ready` is combinational from state only, not from inputs.
- Throughput: 1 write plus 1 lookup per cycle in IDLE.

## Structure
- Shared package `btt_pkg`:
  - state enum `btt_state_t` {CLEAR_ALL, IDLE, CLEAR_BANK}
  - default `D`/`A`/`BANKS` constants
  - reserved-index constant `BTT_NO_BRANCH=0`
- Sub-module `btt_storage`: flat target array plus valid-bit vector. It has one write port, one registered read port and a valid-clear port.
- The top level holds the FSM, clear counter, forwarding and range checks.

## Test plan
- Reset then idle: `busy=1` for exactly 64 cycles, then 0; `wr_ready` rises together with `busy` falling. A lookup during clear gives `hit=0`, `target=0`.
- Write bank0 idx1=9 and bank1 idx1=14; look up (0,1) then (1,1): 9/hit, then 14/hit. Lookup (0,2) gives 0/miss.
- Write idx0=77, then look up idx0: `target=0`, `hit=0`.
- Same-cycle write (1,5)=121 with lookup (1,5): next cycle 121/hit.
- Fill both banks, then `inv_en` bank1: `busy` is high for 32 cycles. Afterwards bank1 lookups miss and bank0 (0,3)=48 still hits.
- Assert `reset` at cycle 20 of CLEAR_BANK: a full 64-cycle CLEAR_ALL follows and all lookups miss.
